// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 4:1 mux select through channels 0..3,
// samples the mux output once per channel and emits a 4-bit word.
module mux_scan_ctrl #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       cont,
    input  logic       y,
    output logic [1:0] s,
    output logic       busy,
    output logic       done,
    output logic [3:0] data
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    shadow;

    // busy is a pure decode of the state register
    assign busy = (state == SCAN);

    // scan sequencer: dwell counting, channel stepping, sampling, word output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            s      <= 2'd0;
            cnt    <= '0;
            shadow <= 3'd0;
            data   <= 4'd0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start && !stop) begin
                    state <= SCAN;
                    s     <= 2'd0;
                    cnt   <= '0;
                end
            end else if (stop) begin
                state <= IDLE;
                s     <= 2'd0;
                cnt   <= '0;
            end else if (cnt != LAST) begin
                cnt <= cnt + CW'(1);
            end else begin
                cnt <= '0;
                case (s)
                    2'd0:    shadow[0] <= y;
                    2'd1:    shadow[1] <= y;
                    2'd2:    shadow[2] <= y;
                    default: ;
                endcase
                if (s != 2'd3) begin
                    s <= s + 2'd1;
                end else begin
                    // last channel goes straight from y into the word
                    data <= {y, shadow};
                    done <= 1'b1;
                    s    <= 2'd0;
                    if (!cont) begin
                        state <= IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed scenarios plus a randomized run against
// a time-based reference model of the scan.
module tb_mux_scan_ctrl;

    localparam int D = 4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       start1;
    logic       stop;
    logic       cont;
    logic [3:0] a4;
    logic [3:0] a1;
    logic       y4;
    logic       y1;
    logic [1:0] s4;
    logic [1:0] s1;
    logic       busy4;
    logic       busy1;
    logic       done4;
    logic       done1;
    logic [3:0] data4;
    logic [3:0] data1;

    int total;
    int bad;

    assign y4 = a4[s4];
    assign y1 = a1[s1];

    mux_scan_ctrl #(.DWELL(D)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .stop  (stop),
        .cont  (cont),
        .y     (y4),
        .s     (s4),
        .busy  (busy4),
        .done  (done4),
        .data  (data4)
    );

    mux_scan_ctrl #(.DWELL(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .stop  (stop),
        .cont  (cont),
        .y     (y1),
        .s     (s1),
        .busy  (busy1),
        .done  (done1),
        .data  (data1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        total++;
        if ({s4, busy4, done4, data4} !== 8'h00) begin
            bad++;
            $display("FAIL reset4 got s=%0d busy=%0b done=%0b data=%b want all zero",
                     s4, busy4, done4, data4);
        end
        total++;
        if ({s1, busy1, done1, data1} !== 8'h00) begin
            bad++;
            $display("FAIL reset1 got s=%0d busy=%0b done=%0b data=%b want all zero",
                     s1, busy1, done1, data1);
        end
    endtask

    task automatic test_single;
        a4    = 4'b1010;
        cont  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 4 * D; j++) begin
            total++;
            if (s4 !== 2'(j / D) || busy4 !== 1'b1 || done4 !== 1'b0) begin
                bad++;
                $display("FAIL single_step j=%0d got s=%0d busy=%0b done=%0b want s=%0d busy=1 done=0",
                         j, s4, busy4, done4, j / D);
            end
            tick();
        end
        total++;
        if (done4 !== 1'b1 || data4 !== 4'b1010 || busy4 !== 1'b0 || s4 !== 2'd0) begin
            bad++;
            $display("FAIL single_done got done=%0b data=%b busy=%0b s=%0d want 1 1010 0 0",
                     done4, data4, busy4, s4);
        end
        tick();
        total++;
        if (done4 !== 1'b0 || data4 !== 4'b1010) begin
            bad++;
            $display("FAIL single_after got done=%0b data=%b want 0 1010", done4, data4);
        end
    endtask

    task automatic test_abort;
        int seen;
        seen  = 0;
        a4    = 4'b1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 10; j++) begin
            if (j == 9) stop = 1'b1;
            if (done4 === 1'b1) seen++;
            tick();
        end
        stop = 1'b0;
        total++;
        if (busy4 !== 1'b0 || s4 !== 2'd0 || data4 !== 4'b1010) begin
            bad++;
            $display("FAIL abort_state got busy=%0b s=%0d data=%b want 0 0 1010",
                     busy4, s4, data4);
        end
        for (int j = 0; j < 20; j++) begin
            if (done4 === 1'b1) seen++;
            tick();
        end
        total++;
        if (seen != 0 || data4 !== 4'b1010) begin
            bad++;
            $display("FAIL abort_nodone got pulses=%0d data=%b want 0 1010", seen, data4);
        end
    endtask

    task automatic test_continuous;
        int n;
        int t0;
        int t1;
        logic [3:0] w0;
        logic [3:0] w1;
        n    = 0;
        t0   = -1;
        t1   = -1;
        w0   = 'x;
        w1   = 'x;
        a4   = 4'b0110;
        cont = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 60; j++) begin
            if (done4 === 1'b1) begin
                if (n == 0) begin
                    t0 = j;
                    w0 = data4;
                    total++;
                    if (s4 !== 2'd0 || busy4 !== 1'b1) begin
                        bad++;
                        $display("FAIL cont_nogap got s=%0d busy=%0b want 0 1", s4, busy4);
                    end
                end else if (n == 1) begin
                    t1 = j;
                    w1 = data4;
                    cont = 1'b0;
                end
                n++;
            end
            if (j == 4 * D + 1) a4 = 4'b1001;
            tick();
        end
        total++;
        if (w0 !== 4'b0110 || w1 !== 4'b1001) begin
            bad++;
            $display("FAIL cont_words got %b,%b want 0110,1001", w0, w1);
        end
        total++;
        if (t0 != 4 * D || t1 - t0 != 4 * D) begin
            bad++;
            $display("FAIL cont_period got t0=%0d gap=%0d want %0d %0d", t0, t1 - t0, 4 * D, 4 * D);
        end
        total++;
        if (n != 3 || busy4 !== 1'b0 || data4 !== 4'b1001) begin
            bad++;
            $display("FAIL cont_stop got pulses=%0d busy=%0b data=%b want 3 0 1001", n, busy4, data4);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        seen  = 0;
        a4    = 4'b1011;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 5; j++) tick();
        total++;
        if (s4 !== 2'd1) begin
            bad++;
            $display("FAIL rstmid_pre got s=%0d want 1", s4);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++;
        if ({s4, busy4, done4, data4} !== 8'h00) begin
            bad++;
            $display("FAIL rstmid_state got s=%0d busy=%0b done=%0b data=%b want all zero",
                     s4, busy4, done4, data4);
        end
        for (int j = 0; j < 25; j++) begin
            if (done4 === 1'b1) seen++;
            tick();
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL rstmid_nodone got pulses=%0d want 0", seen);
        end
    endtask

    task automatic test_start_held;
        int first;
        int n;
        first = -1;
        n     = 0;
        a4    = 4'b0101;
        start = 1'b1;
        tick();
        for (int j = 0; j <= 4 * D; j++) begin
            if (j == 4 * D - 1) start = 1'b0;
            if (done4 === 1'b1) begin
                n++;
                if (first < 0) first = j;
            end
            if (j < 4 * D) tick();
        end
        total++;
        if (first != 4 * D || n != 1 || data4 !== 4'b0101) begin
            bad++;
            $display("FAIL start_held got first=%0d pulses=%0d data=%b want %0d 1 0101",
                     first, n, data4, 4 * D);
        end
        tick();
    endtask

    task automatic test_start_stop;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        total++;
        if (busy4 !== 1'b0 || s4 !== 2'd0) begin
            bad++;
            $display("FAIL start_stop got busy=%0b s=%0d want 0 0", busy4, s4);
        end
        tick();
        tick();
        total++;
        if (busy4 !== 1'b0 || done4 !== 1'b0) begin
            bad++;
            $display("FAIL start_stop_hold got busy=%0b done=%0b want 0 0", busy4, done4);
        end
    endtask

    task automatic test_dwell1;
        a1     = 4'b0001;
        cont   = 1'b0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int j = 0; j < 4; j++) begin
            total++;
            if (s1 !== 2'(j) || busy1 !== 1'b1 || done1 !== 1'b0) begin
                bad++;
                $display("FAIL dwell1_step j=%0d got s=%0d busy=%0b done=%0b want s=%0d 1 0",
                         j, s1, busy1, done1, j);
            end
            tick();
        end
        total++;
        if (done1 !== 1'b1 || data1 !== 4'b0001 || busy1 !== 1'b0) begin
            bad++;
            $display("FAIL dwell1_done got done=%0b data=%b busy=%0b want 1 0001 0",
                     done1, data1, busy1);
        end
    endtask

    // reference: scan position is elapsed cycles t in 0..4D-1; channel t/D
    task automatic test_random;
        bit         m_busy;
        int         m_t;
        logic [3:0] m_word;
        logic [3:0] m_data;
        bit         m_done;
        logic [1:0] m_s;
        rst_n = 1'b0;
        tick();
        rst_n  = 1'b1;
        m_busy = 0;
        m_t    = 0;
        m_word = 4'd0;
        m_data = 4'd0;
        m_done = 0;
        for (int c = 0; c < 400; c++) begin
            start = ($urandom_range(0, 3) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            cont  = ($urandom_range(0, 1) == 1);
            a4    = 4'($urandom_range(0, 15));
            m_done = 0;
            if (!m_busy) begin
                if (start && !stop) begin
                    m_busy = 1;
                    m_t    = 0;
                end
            end else if (stop) begin
                m_busy = 0;
            end else begin
                if (m_t % D == D - 1) m_word[m_t / D] = a4[m_t / D];
                if (m_t == 4 * D - 1) begin
                    m_data = m_word;
                    m_done = 1;
                    m_t    = 0;
                    m_busy = cont;
                end else begin
                    m_t++;
                end
            end
            m_s = m_busy ? 2'(m_t / D) : 2'd0;
            tick();
            total++;
            if (s4 !== m_s || busy4 !== m_busy || done4 !== m_done || data4 !== m_data) begin
                bad++;
                $display("FAIL random c=%0d got s=%0d busy=%0b done=%0b data=%b want s=%0d busy=%0b done=%0b data=%b",
                         c, s4, busy4, done4, data4, m_s, m_busy, m_done, m_data);
            end
        end
        start = 1'b0;
        stop  = 1'b0;
        cont  = 1'b0;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b1;
        start  = 1'b0;
        start1 = 1'b0;
        stop   = 1'b0;
        cont   = 1'b0;
        a4     = 4'd0;
        a1     = 4'd0;
        #2;
        test_reset();
        test_single();
        test_abort();
        test_continuous();
        test_start_held();
        test_start_stop();
        test_reset_mid();
        test_dwell1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Sequencer that drives the 2-bit select of a 4:1 multiplexer and consumes its 1-bit output. It steps s through channels 0..3 and holds each channel for DWELL cycles so the mux output can settle. It samples y once per channel and, after channel 3, presents the four samples as one parallel word with a done pulse.

Parameters:
DWELL, 4, clock cycles each channel is held on s; legal range 1..255; y is sampled on the last cycle of the dwell.

Ports:
clk    input   1  system clock, all state updates on rising edge
rst_n  input   1  synchronous reset, active-low
start  input   1  begin a scan; sampled only in IDLE
stop   input   1  abort the current scan; sampled in SCAN
cont   input   1  1 = restart at channel 0 after each completed scan; sampled at completion edge
y      input   1  multiplexer output for the channel currently on s
s      output  2  multiplexer select
busy   output  1  1 while in SCAN
done   output  1  one-cycle pulse: new word valid on data
data   output  4  captured word; data[i] = y sampled while s == i

Behaviour:
- One clock. Reset is synchronous and active-low: rst_n low at a clk rising edge resets the block.
- Reset values: state=IDLE, s=2'b00, busy=0, done=0, data=4'b0000, dwell counter=0, shadow register=0.
- Reset mid-scan aborts with no done pulse and clears data.
- States:
  - IDLE: s=0, busy=0.
  - SCAN: s=current channel, busy=1.
- IDLE -> SCAN:
  - Triggered when start=1 and stop=0 at an edge.
  - Next cycle: s=0, counter=0, busy=1.
  - If start=1 and stop=1 together in IDLE, stop wins and the block stays in IDLE.
- SCAN, each edge, in priority order:
  1. If stop=1: go to IDLE, s=0, busy=0. data is unchanged and no done pulse.
  2. Else if counter < DWELL-1: increment counter.
  3. Else (counter == DWELL-1):
     - Write y into shadow[s] and clear the counter.
     - If s<3, increment s.
     - If s==3: load data with the shadow, taking bit 3 directly from y this edge, and set done=1 for the next cycle only.
     - Then, if cont=1: stay in SCAN with s=0.
     - If cont=0: go to IDLE with s=0 and busy=0.
- done is high for exactly one cycle per completed scan. It is high in the same cycle data first shows the new word.
- data holds its value until the next completed scan.
- start is ignored while in SCAN; it has no effect and is not queued.
- Latency: with start sampled at edge E, done is high in the cycle after edge E+4*DWELL.
  - With DWELL=4, done follows edge E+16.
- Scans in cont mode are back-to-back with no idle gap. The period is 4*DWELL cycles per word.
- s changes only on clk edges and is glitch-free. Each channel is present on s for exactly DWELL cycles.
- DWELL=1: sample every cycle; s changes every cycle. The counter is a constant 0 and the design must still be legal.
- Counter width: the minimum needed to hold DWELL-1, at least 1 bit.

Test Plan:
- Single scan: reset, then connect a mux with a=4'b1010 and DWELL=4. Pulse start for 1 cycle. Required response:
  - s is 0,1,2,3 for 4 cycles each.
  - done is high for one cycle, 16 edges after start.
  - data=4'b1010, busy=0 afterwards.
- Continuous: cont=1 and a=4'b0110. Change a to 4'b1001 during the second scan's channel 0 dwell. Required response:
  - First done gives data=4'b0110, second gives 4'b1001.
  - The two done pulses are exactly 16 cycles apart.
  - s returns to 0 with no gap.
- Abort: a=4'b1111. Assert stop during channel 2. Required response:
  - Next cycle: busy=0, s=0.
  - No done pulse; data keeps its previous value, 4'b1010 from the first test.
- Reset mid-scan: drive rst_n=0 for 1 edge during channel 1. Required response: data=0, s=0, busy=0, done=0, and no done pulse afterwards.
- Corner cases:
  - start held high during SCAN: no restart, and done still arrives at the original time.
  - start=stop=1 in IDLE: stays in IDLE.
- DWELL=1 build with a=4'b0001: s steps 0,1,2,3 on consecutive cycles, then done with data=4'b0001, 4 edges after start.
